mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Parametrised byte-serial memory controller between the CPU's memory clients (i-cache line fill, LSB load/store) and the 8-bit RAM/IO bus. Arbitrates NUM_PORTS requesters round-robin, serialises transfers of 1..MAX_BYTES bytes, and returns little-endian read data with optional sign extension. Adds UART back-pressure handling and selective flush of speculative reads.

## Interface
- NUM_PORTS, 2: number of requesters.
- MAX_BYTES, 16: largest transfer in bytes (≥4).
- LEN_W, $clog2(MAX_BYTES+1): width of one length field.
- FLUSH_MASK, 'b01: bit p set means port p's reads are aborted by flush_in.
- clk_in  in  1  system clock; one clock domain.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global enable; low freezes the block.
- flush_in  in  1  one-cycle pipeline flush (mispredict).
- mem_din  in  8  RAM read data, valid one cycle after its address.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM address; bits 17:16 == 2'b11 select IO.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART FIFO full.
- req_valid  in  NUM_PORTS  per-port request; held until req_gnt.
- req_wr  in  NUM_PORTS  1 = write.
- req_signed  in  NUM_PORTS  sign-extend read result.
- req_addr  in  32*NUM_PORTS  start address per port.
- req_len  in  LEN_W*NUM_PORTS  byte count per port.
- req_wdata  in  8*MAX_BYTES*NUM_PORTS  write bytes, byte 0 in bits 7:0.
- req_gnt  out  NUM_PORTS  one-hot; request fields captured this cycle.
- resp_valid  out  NUM_PORTS  one-hot one-cycle completion pulse.
- resp_data  out  8*MAX_BYTES  read result, shared by all ports.

## Operation
- States: IDLE, XFER, TAIL.
- IDLE: rr_arbiter picks the first valid port starting at pointer rr; req_gnt is combinational, asserted only in IDLE. On grant, capture wr, signed, addr, len, wdata, port id; clear byte counter k; go to XFER; rr <= granted+1 mod NUM_PORTS.
- req_len 0: never granted. req_len > MAX_BYTES: treated as MAX_BYTES.
- XFER: drive mem_a = addr+k, mem_wr = wr, mem_dout = wdata byte k. For reads, capture mem_din into byte k-1 when k ≥ 1. After byte n-1 is issued, go to TAIL for reads or IDLE for writes.
- TAIL (reads only): capture byte n-1; go to IDLE.
- Response: registered one-hot resp_valid pulse on entry to IDLE.
  - Read: bytes 0..n-1 hold the read data. Bytes n..MAX_BYTES-1 are filled with byte n-1 bit 7 when signed, else 0.
  - Write: resp_data = 0.
- IO stall: if the next byte is a write to an IO address and io_buffer_full = 1, register mem_wr = 0 and hold k. Each IO byte is written exactly once.
- Flush: flush_in aborts the current transfer only if it is a read from a FLUSH_MASK port. Abort means next state IDLE, no resp, mem_wr = 0. Writes and unmasked ports always complete. In IDLE, flush_in blocks grants to masked ports for that cycle. A resp pulse already registered is not revoked.
- rdy_in low: state, counters, rr and captured data hold; mem_wr is forced to 0 combinationally; req_gnt = 0; resp_valid holds its registered value. mem_din is not sampled while rdy_in is low.

## Timing
- Reset values: mem_a 0, mem_dout 0, mem_wr 0, req_gnt 0, resp_valid 0, resp_data 0, rr 0, state IDLE.
- Reset mid-transfer drops it silently.
- n = byte count, G = grant cycle.
- Read of n bytes: address byte k at G+1+k; resp_valid at G+n+2.
- Write of n bytes: resp_valid at G+n+1.
- Each IO-stall cycle and each rdy_in-low cycle adds one cycle.
- A new grant may occur in the same cycle resp_valid is high.

## Structure
- mem_ctrl_pkg holds:
  - the state enum (IDLE/XFER/TAIL);
  - IO_SEL = 2'b11 and the IO bit positions 17:16;
  - an is_io(addr) function.
- Sub-module rr_arbiter (parameter N): inputs req and ptr; output one-hot gnt.
- Byte-lane capture and sign-fill logic stay in mem_ctrl.

## Test plan
- Port 0 signed read, addr 0x100, len 4, RAM bytes 78 56 34 12 -> resp_valid[0] at G+6, resp_data[31:0] = 0x12345678, upper bytes 0.
- Port 1 read, len 1, byte 0x80 -> signed: all upper bytes 0xFF; unsigned: resp_data = 0x80.
- Both ports hold req_valid with len 2 -> grants alternate 0, 1, 0, 1; each resp follows its grant by 4 cycles.
- Port 1 write, len 2, addr 0x30000, io_buffer_full high 3 cycles at the first byte -> mem_wr low for those cycles; each byte written once; resp at G+6.
- Port 0 16-byte read with flush_in at k = 5 -> no resp, IDLE next cycle. Port 1 write with flush_in -> completes with resp.
- rdy_in low 2 cycles mid 4-byte read -> mem_wr 0 throughout, resp at G+8, data correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and IO address decode for mem_ctrl
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        TAIL
    } state_e;

    localparam logic [1:0] IO_SEL = 2'b11;
    localparam int         IO_HI  = 17;
    localparam int         IO_LO  = 16;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[IO_HI:IO_LO] == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// rtl/mem_ctrl_rr_arbiter.sv - rotating-priority one-hot arbiter starting at ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        logic found;
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + i) % N)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - round-robin byte-serial memory controller with sign fill, IO stall and flush
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                   NUM_PORTS  = 2,
    parameter int                   MAX_BYTES  = 16,
    parameter int                   LEN_W      = $clog2(MAX_BYTES + 1),
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 'b01
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           flush_in,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [31:0]                    mem_a,
    output logic                           mem_wr,
    input  logic                           io_buffer_full,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS-1:0]           req_wr,
    input  logic [NUM_PORTS-1:0]           req_signed,
    input  logic [32*NUM_PORTS-1:0]        req_addr,
    input  logic [LEN_W*NUM_PORTS-1:0]     req_len,
    input  logic [8*MAX_BYTES*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           req_gnt,
    output logic [NUM_PORTS-1:0]           resp_valid,
    output logic [8*MAX_BYTES-1:0]         resp_data
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DW     = 8 * MAX_BYTES;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      k_q, k_d, n_q, n_d;
    logic [31:0]           addr_q, addr_d;
    logic                  wr_q, wr_d, sgn_q, sgn_d;
    logic [PORT_W-1:0]     port_q, port_d, rr_q, rr_d;
    logic [DW-1:0]         wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [NUM_PORTS-1:0]  resp_valid_q, resp_valid_d;
    logic [DW-1:0]         resp_data_q, resp_data_d;

    logic [NUM_PORTS-1:0]  elig, arb_req, gnt;
    logic [PORT_W-1:0]     sel_idx;
    logic [31:0]           sel_addr, byte_addr;
    logic [LEN_W-1:0]      sel_len, len_eff, cap_idx;
    logic                  sel_wr, sel_sgn, stall, abort, re_addr;
    logic [DW-1:0]         sel_wdata;

    rr_arbiter #(.N(NUM_PORTS), .PTR_W(PORT_W)) u_arb (
        .req (arb_req),
        .ptr (rr_q),
        .gnt (gnt)
    );

    always_comb begin
        elig      = '0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wr    = 1'b0;
        sel_sgn   = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req_valid[i] && (req_len[LEN_W*i +: LEN_W] != '0)
                      && !(flush_in && FLUSH_MASK[i]);
            if (gnt[i]) begin
                sel_idx   = PORT_W'(i);
                sel_addr  = req_addr[32*i +: 32];
                sel_len   = req_len[LEN_W*i +: LEN_W];
                sel_wr    = req_wr[i];
                sel_sgn   = req_signed[i];
                sel_wdata = req_wdata[DW*i +: DW];
            end
        end
        len_eff = (sel_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len;
    end

    assign arb_req = (state_q == IDLE && rdy_in) ? elig : '0;
    assign req_gnt = gnt;

    // While frozen, re-present the previous byte's address so mem_din still
    // carries byte k-1 on the first cycle after rdy_in returns.
    always_comb begin
        byte_addr = addr_q + 32'(k_q);
        stall     = (state_q == XFER) && wr_q && is_io(byte_addr) && io_buffer_full;
        re_addr   = (state_q == TAIL) || (state_q == XFER && !rdy_in && k_q != '0);
        mem_a     = byte_addr - (re_addr ? 32'd1 : 32'd0);
        mem_wr    = rdy_in && (state_q == XFER) && wr_q && !stall;
        mem_dout  = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (k_q == LEN_W'(i)) mem_dout = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        sgn_d        = sgn_q;
        port_d       = port_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        rr_d         = rr_q;
        resp_valid_d = rdy_in ? '0 : resp_valid_q;
        resp_data_d  = resp_data_q;
        abort        = flush_in && !wr_q && FLUSH_MASK[port_q];
        cap_idx      = k_q - LEN_W'(1);

        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        state_d = XFER;
                        k_d     = '0;
                        n_d     = len_eff;
                        addr_d  = sel_addr;
                        wr_d    = sel_wr;
                        sgn_d   = sel_sgn;
                        port_d  = sel_idx;
                        wdata_d = sel_wdata;
                        rr_d    = (sel_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : sel_idx + PORT_W'(1);
                    end
                end
                XFER: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (!stall) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (!wr_q && k_q != '0 && cap_idx == LEN_W'(i))
                                rbuf_d[8*i +: 8] = mem_din;
                        end
                        k_d = k_q + LEN_W'(1);
                        if (k_q == n_q - LEN_W'(1)) begin
                            if (wr_q) begin
                                state_d      = IDLE;
                                resp_valid_d = NUM_PORTS'(1) << port_q;
                                resp_data_d  = '0;
                            end else begin
                                state_d = TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    state_d = IDLE;
                    if (!abort) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (cap_idx == LEN_W'(i)) rbuf_d[8*i +: 8] = mem_din;
                        end
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (LEN_W'(i) >= n_q)
                                resp_data_d[8*i +: 8] = sgn_q ? {8{mem_din[7]}} : 8'h00;
                            else
                                resp_data_d[8*i +: 8] = rbuf_d[8*i +: 8];
                        end
                        resp_valid_d = NUM_PORTS'(1) << port_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            k_q          <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            sgn_q        <= 1'b0;
            port_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            rr_q         <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            sgn_q        <= sgn_d;
            port_q       <= port_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl
module tb_mem_ctrl;

    localparam int NP = 2;
    localparam int MB = 16;
    localparam int LW = 5;

    logic              clk = 1'b0;
    logic              rst, rdy, flush, io_full;
    logic [7:0]        mem_din, mem_dout;
    logic [31:0]       mem_a;
    logic              mem_wr;
    logic [NP-1:0]     req_valid, req_wr, req_signed, req_gnt, resp_valid;
    logic [32*NP-1:0]  req_addr;
    logic [LW*NP-1:0]  req_len;
    logic [8*MB*NP-1:0] req_wdata;
    logic [8*MB-1:0]   resp_data;

    typedef struct { int port; logic [127:0] data; int cyc; } exp_t;
    typedef struct { int port; int cyc; } gnt_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;

    exp_t         sb[$];
    gnt_t         glog[$];
    wr_t          wlog[$];
    exp_t         mon_e;
    logic [127:0] exp_data [NP];
    int           exp_lat  [NP];
    bit           exp_resp [NP];
    logic [7:0]   ram [0:1023];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    mem_ctrl #(.NUM_PORTS(NP), .MAX_BYTES(MB), .LEN_W(LW), .FLUSH_MASK(2'b01)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .flush_in       (flush),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wdata      (req_wdata),
        .req_gnt        (req_gnt),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_din <= ram[mem_a[9:0]];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", resp_valid, '0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_port", resp_valid, NP'(1) << mon_e.port);
                    chk("resp_data", resp_data, mon_e.data);
                    chk("resp_cycle", cyc, mon_e.cyc);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (req_gnt[p]) begin
                    glog.push_back('{p, cyc});
                    if (exp_resp[p]) sb.push_back('{p, exp_data[p], cyc + exp_lat[p]});
                end
            end
            if (mem_wr) wlog.push_back('{mem_a, mem_dout, cyc});
        end
    end

    task automatic set_port(input int p, input bit w, input bit s, input logic [31:0] a,
                            input logic [LW-1:0] l, input logic [127:0] wd,
                            input logic [127:0] ed, input int lat, input bit er);
        req_wr[p]             = w;
        req_signed[p]         = s;
        req_addr[32*p +: 32]  = a;
        req_len[LW*p +: LW]   = l;
        req_wdata[128*p +: 128] = wd;
        exp_data[p]           = ed;
        exp_lat[p]            = lat;
        exp_resp[p]           = er;
    endtask

    task automatic wait_gnt(input int p, output int g);
        g = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req_gnt[p]) begin
                g = cyc;
                break;
            end
        end
        if (g < 0) chk("gnt_timeout", req_gnt[p], 1'b1);
    endtask

    task automatic issue(input int p, output int g);
        req_valid[p] = 1'b1;
        wait_gnt(p, g);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int g, g1, c0, gi, ng;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        req_valid = '0; req_wr = '0; req_signed = '0;
        req_addr = '0; req_len = '0; req_wdata = '0;
        for (int p = 0; p < NP; p++) begin
            exp_data[p] = '0; exp_lat[p] = 0; exp_resp[p] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
        ram[10'h200] = 8'h80;
        ram[10'h010] = 8'h11; ram[10'h011] = 8'h22;
        ram[10'h020] = 8'h33; ram[10'h021] = 8'h44;
        for (int i = 0; i < 16; i++) ram[10'h300 + i] = 8'(i + 1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", mem_dout, 8'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_req_gnt", req_gnt, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_data", resp_data, 128'h0);
        @(posedge clk); #1;

        // signed 4-byte read, then signed/unsigned single byte 0x80
        set_port(0, 0, 1, 32'h100, 4, '0, 128'h12345678, 6, 1);
        issue(0, g);
        set_port(1, 0, 1, 32'h200, 1, '0, {{15{8'hFF}}, 8'h80}, 3, 1);
        issue(1, g);
        set_port(1, 0, 0, 32'h200, 1, '0, 128'h80, 3, 1);
        issue(1, g);
        idle(4);

        // both ports contending: grants alternate every 4 cycles
        set_port(0, 0, 0, 32'h10, 2, '0, 128'h2211, 4, 1);
        set_port(1, 0, 0, 32'h20, 2, '0, 128'h4433, 4, 1);
        gi = glog.size();
        ng = 0;
        req_valid = 2'b11;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (|req_gnt) ng++;
            if (ng == 4) break;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("rr_grant_count", glog.size() - gi, 4);
        if (glog.size() >= gi + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_grant_port", glog[gi+k].port, k % 2);
                if (k > 0) chk("rr_grant_gap", glog[gi+k].cyc - glog[gi+k-1].cyc, 4);
            end
        end
        idle(5);

        // IO write stalled three cycles on the first byte
        wlog.delete();
        set_port(1, 1, 0, 32'h30000, 2, 128'h5AA5, 128'h0, 6, 1);
        req_valid[1] = 1'b1;
        wait_gnt(1, g);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        io_full = 1'b1;
        idle(3);
        io_full = 1'b0;
        idle(3);
        chk("io_write_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("io_w0_addr", wlog[0].a, 32'h30000);
            chk("io_w0_data", wlog[0].d, 8'hA5);
            chk("io_w0_cycle", wlog[0].cyc, g + 4);
            chk("io_w1_addr", wlog[1].a, 32'h30001);
            chk("io_w1_data", wlog[1].d, 8'h5A);
            chk("io_w1_cycle", wlog[1].cyc, g + 5);
        end

        // masked read flushed at k=5; port 1 write granted the next cycle
        set_port(0, 0, 0, 32'h300, 16, '0, '0, 0, 0);
        req_valid[0] = 1'b1;
        wait_gnt(0, g);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_port(1, 1, 0, 32'h40, 1, 128'h77, 128'h0, 2, 1);
        req_valid[1] = 1'b1;
        idle(5);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        wait_gnt(1, g1);
        chk("flush_idle_next", g1, g + 7);
        @(posedge clk); #1;

        // unmasked write completes despite flush
        set_port(1, 1, 0, 32'h50, 2, 128'hBBAA, 128'h0, 3, 1);
        wait_gnt(1, g);
        chk("gnt_with_resp_cycle", g, g1 + 2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        flush = 1'b1;
        idle(2);
        flush = 1'b0;
        idle(4);

        // flush in IDLE blocks a masked port for that cycle only
        set_port(0, 0, 0, 32'h200, 1, '0, 128'h80, 3, 1);
        req_valid[0] = 1'b1;
        flush = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("flush_blocks_gnt", req_gnt, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0;
        wait_gnt(0, g);
        chk("gnt_after_flush", g, c0 + 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        idle(4);

        // zero length is never granted
        set_port(0, 0, 0, 32'h100, 0, '0, '0, 0, 0);
        req_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("len0_no_gnt", req_gnt, 2'b00);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;

        // oversize length clamps to MAX_BYTES
        set_port(0, 0, 0, 32'h300, 20, '0, 128'h100F0E0D0C0B0A090807060504030201, 18, 1);
        issue(0, g);

        // rdy_in low for two cycles in the middle of a 4-byte read
        set_port(0, 0, 0, 32'h100, 4, '0, 128'h12345678, 8, 1);
        issue(0, g);
        idle(1);
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("frozen_mem_wr", mem_wr, 1'b0);
            chk("frozen_req_gnt", req_gnt, 2'b00);
            @(posedge clk); #1;
        end
        rdy = 1'b1;

        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", sb.size(), 0);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
